// File: rtl/fpmul_result_fifo.sv
// fpmul_result_fifo: FWFT output buffer for binary32 multiplier products.
// Optional feature macro FPRF_CLASS_EN adds a per-entry IEEE class tag,
// the out_class port and live NaN/Inf saturating counters.
module fpmul_result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [31:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
`ifdef FPRF_CLASS_EN
    output logic [2:0]               out_class,
`endif
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         nan_cnt,
    output logic [CNT_W-1:0]         inf_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
`ifdef FPRF_CLASS_EN
    localparam int unsigned ENT_W = 35;
`else
    localparam int unsigned ENT_W = 32;
`endif

`ifdef FPRF_CLASS_EN
    // IEEE class of a binary32 word; sign is ignored
    function automatic logic [2:0] classify(input logic [31:0] w);
        logic [7:0]  e;
        logic [22:0] f;
        e = w[30:23];
        f = w[22:0];
        if (e == 8'd0) begin
            classify = (f == 23'd0) ? 3'd0 : 3'd1;
        end else if (e == 8'hFF) begin
            if (f == 23'd0)      classify = 3'd3;
            else if (f[22])      classify = 3'd4;
            else                 classify = 3'd5;
        end else begin
            classify = 3'd2;
        end
    endfunction
`endif

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [ENT_W-1:0] entry;
    logic             push;
    logic             pop;

    // Handshake decode from registered occupancy only
    assign in_ready  = (level_q != LVL_W'(DEPTH));
    assign out_valid = (level_q != LVL_W'(0));
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign level     = level_q;
    assign out_data  = mem_q[rd_ptr_q][31:0];

`ifdef FPRF_CLASS_EN
    assign entry     = {classify(in_data), in_data};
    assign out_class = mem_q[rd_ptr_q][34:32];
`else
    assign entry     = in_data;
`endif

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // FIFO state registers; reset wipes stored words
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

`ifdef FPRF_CLASS_EN
    logic [CNT_W-1:0] nan_cnt_q, nan_cnt_d;
    logic [CNT_W-1:0] inf_cnt_q, inf_cnt_d;
    logic [2:0]       in_class;

    assign in_class = entry[34:32];
    assign nan_cnt  = nan_cnt_q;
    assign inf_cnt  = inf_cnt_q;

    // Saturating NaN/Inf counters advanced by accepted pushes only
    always_comb begin
        nan_cnt_d = nan_cnt_q;
        inf_cnt_d = inf_cnt_q;
        if (push && (in_class == 3'd4 || in_class == 3'd5) && (nan_cnt_q != '1)) begin
            nan_cnt_d = nan_cnt_q + CNT_W'(1);
        end
        if (push && (in_class == 3'd3) && (inf_cnt_q != '1)) begin
            inf_cnt_d = inf_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            nan_cnt_q <= '0;
            inf_cnt_q <= '0;
        end else begin
            nan_cnt_q <= nan_cnt_d;
            inf_cnt_q <= inf_cnt_d;
        end
    end
`else
    assign nan_cnt = '0;
    assign inf_cnt = '0;
`endif

endmodule

// File: tb/tb_fpmul_result_fifo.sv
// Scoreboard bench for fpmul_result_fifo (works with or without FPRF_CLASS_EN).
module tb_fpmul_result_fifo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 3;
    localparam int          CMAX  = 7;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [31:0]              in_data = '0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [31:0]              out_data;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
`ifdef FPRF_CLASS_EN
    logic [2:0]               out_class;
`endif
    logic [$clog2(DEPTH):0]   level;
    logic [CNT_W-1:0]         nan_cnt;
    logic [CNT_W-1:0]         inf_cnt;

    fpmul_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef FPRF_CLASS_EN
        .out_class (out_class),
`endif
        .level     (level),
        .nan_cnt   (nan_cnt),
        .inf_cnt   (inf_cnt)
    );

    always #5 clk = ~clk;

    int          n_pass = 0;
    int          n_total = 0;
    int          n_popped = 0;
    logic [31:0] exp_q [$];
    int          mlev = 0;
    int          mnan = 0;
    int          minf = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // IEEE class by the textbook rules
    function automatic int cls(input logic [31:0] w);
        int e;
        int f;
        e = int'(w[30:23]);
        f = int'(w[22:0]);
        if (e == 0) return (f == 0) ? 0 : 1;
        if (e == 255) begin
            if (f == 0) return 3;
            return (f >= 32'h400000) ? 4 : 5;
        end
        return 2;
    endfunction

    // Stimulus side: record every accepted word as expected output
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) exp_q.push_back(in_data);
    end

    // Monitor: compare DUT against model occupancy, scoreboard head and counters
    always @(negedge clk) begin
        bit pm;
        bit pp;
        if (rst) begin
            exp_q.delete();
            mlev = 0;
            mnan = 0;
            minf = 0;
        end else begin
            chk("level", 32'(level), 32'(mlev));
            chk("in_ready", 32'(in_ready), 32'(mlev != DEPTH));
            chk("out_valid", 32'(out_valid), 32'(mlev != 0));
`ifdef FPRF_CLASS_EN
            chk("nan_cnt", 32'(nan_cnt), 32'(mnan));
            chk("inf_cnt", 32'(inf_cnt), 32'(minf));
`else
            chk("nan_cnt", 32'(nan_cnt), 32'd0);
            chk("inf_cnt", 32'(inf_cnt), 32'd0);
`endif
            if (mlev != 0) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_nonempty", 32'd0, 32'd1);
                end else begin
                    chk("out_data", out_data, exp_q[0]);
`ifdef FPRF_CLASS_EN
                    chk("out_class", 32'(out_class), 32'(cls(exp_q[0])));
`endif
                end
            end
            pp = in_valid && (mlev != DEPTH);
            pm = out_ready && (mlev != 0);
            if (pm && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                n_popped++;
            end
            if (pp) begin
                if (cls(in_data) >= 4 && mnan < CMAX) mnan++;
                if (cls(in_data) == 3 && minf < CMAX) minf++;
            end
            mlev = mlev + int'(pp) - int'(pm);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Offer a word until accepted (bounded)
    task automatic push_word(input logic [31:0] d);
        bit acc;
        acc = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            cyc();
        end
        in_valid = 1'b0;
        if (!acc) chk("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) cyc();
        cyc();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
    endtask

    logic [31:0] specials [6] = '{32'h80000000, 32'h00000001, 32'h7F800000,
                                  32'h7FC00000, 32'h7F800001, 32'hFF800000};

    initial begin
        int base;
        // Reset and idle
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_nan", 32'(nan_cnt), 32'd0);
        chk("rst_inf", 32'(inf_cnt), 32'd0);
`ifdef FPRF_CLASS_EN
        chk("rst_out_class", 32'(out_class), 32'd0);
`endif

        // Single word held under back-pressure
        push_word(32'h40400000);
        chk("one_valid", 32'(out_valid), 32'd1);
        chk("one_data", out_data, 32'h40400000);
        chk("one_level", 32'(level), 32'd1);
        repeat (3) cyc();
        chk("one_hold", out_data, 32'h40400000);
        drain();

        // Special values streamed through
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) push_word(specials[i]);
        drain();

        // Full: refuse 5th, refuse push during pop, accept afterwards
        for (int i = 0; i < 4; i++) push_word(32'h41000000 + 32'(i));
        chk("full_level", 32'(level), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data  = 32'h42000000;
        repeat (2) cyc();
        chk("full_refused", 32'(level), 32'd4);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("full_pop_push", 32'(level), 32'd3);
        cyc();
        in_valid = 1'b0;
        chk("after_full_push", 32'(level), 32'd4);
        drain();

        // Stream 10 words with toggling consumer, across pointer wrap
        base = n_popped;
        fork
            begin
                for (int i = 0; i < 10; i++) push_word(32'h3F800000 + 32'(i));
            end
            begin
                for (int i = 0; i < 30; i++) begin
                    out_ready = ~out_ready;
                    cyc();
                end
            end
        join
        drain();
        chk("stream_count", 32'(n_popped - base), 32'd10);

        // Randomized traffic, biased toward special values so counters saturate
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            in_data   = ($urandom_range(1) != 0) ? specials[$urandom_range(5)] : $urandom;
            cyc();
        end
        in_valid = 1'b0;
        drain();

        // Reset during simultaneous push and pop discards contents
        for (int i = 0; i < 3; i++) push_word(32'h44000000 + 32'(i));
        in_valid  = 1'b1;
        in_data   = 32'h7F800000;
        out_ready = 1'b1;
        rst       = 1'b1;
        cyc();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("midrst_level", 32'(level), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_nan", 32'(nan_cnt), 32'd0);
        chk("midrst_inf", 32'(inf_cnt), 32'd0);
        push_word(32'h12345678);
        chk("post_rst_data", out_data, 32'h12345678);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fpmul_result_fifo.md
# fpmul_result_fifo

Output buffer downstream of the FP single-precision multiplier wrapper. It accepts IEEE-754 binary32 products over a valid/ready handshake and stores them in a first-word-fall-through FIFO. It delivers them to the consumer over a second valid/ready handshake, so multiplier back-pressure is decoupled from the consumer. It also tags each word with an IEEE class code and keeps saturating counters of NaN and infinity results for the bench.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- CNT_W, 16, width of the statistics counters

Ports:
- clk  in  1  single clock, all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  32  binary32 product from the multiplier stage
- in_valid  in  1  in_data is valid
- in_ready  out  1  FIFO can accept a word this cycle
- out_data  out  32  head-of-FIFO word
- out_valid  out  1  FIFO is non-empty
- out_ready  in  1  consumer takes the head word this cycle
- out_class  out  3  class of the head word (only with FPRF_CLASS_EN)
- level  out  $clog2(DEPTH)+1  current occupancy
- nan_cnt  out  CNT_W  saturating count of accepted NaN words
- inf_cnt  out  CNT_W  saturating count of accepted ±Inf words

## Operation
- Push: in_valid && in_ready at an edge writes in_data at wr_ptr, then wr_ptr+1 (mod DEPTH).
- Pop: out_valid && out_ready at an edge advances rd_ptr (mod DEPTH).
- level: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- in_ready = (level != DEPTH). This is a combinational decode of registered state, with no dependency on in_valid or out_ready.
- out_valid = (level != 0). out_data = mem[rd_ptr].
- No bypass:
  - Full: a push is refused even if a pop happens in the same cycle.
  - Empty: the incoming word is not visible on out_data in the same cycle.
- Class codes, decoded from exponent E[30:23] and fraction F[22:0]; the sign is ignored:
  - 0: zero (E=0, F=0)
  - 1: subnormal (E=0, F≠0)
  - 2: normal
  - 3: infinity (E=255, F=0)
  - 4: quiet NaN (E=255, F[22]=1)
  - 5: signalling NaN (E=255, F[22]=0, F≠0)
  - 6–7: unused
- Statistics counters:
  - nan_cnt increments on each accepted push of class 4 or 5.
  - inf_cnt increments on each accepted push of class 3.
  - Both saturate at 2^CNT_W−1.
  - Both are independent of pops.
- Reset (rst=1 at an edge) sets wr_ptr, rd_ptr, level, nan_cnt and inf_cnt to 0 and clears memory to 0.
  - Reset overrides any push or pop in the same cycle.
  - Reset mid-stream discards all stored words.

## Timing
- Output values in the cycle after reset: in_ready=1, out_valid=0, out_data=0, out_class=0, level=0, nan_cnt=0, inf_cnt=0.
- Latency: a word pushed at edge N has out_valid=1 and out_data valid after edge N, so it can be popped at edge N+1.
- Throughput: one push and one pop per cycle, sustained while 0 < level < DEPTH.
- Wrap-around: pointers roll from DEPTH−1 to 0. Order is preserved across the wrap.
- Counters and level settle in the same edge as the push or pop that changes them.
- out_data and out_class stay stable while out_valid=1 and out_ready=0.

## Configuration
- FPRF_CLASS_EN defined:
  - Each stored entry is 35 bits: data plus a class code computed at push time.
  - out_class is present.
  - nan_cnt and inf_cnt are live.
- FPRF_CLASS_EN undefined:
  - Entries are 32 bits and no classifier logic exists.
  - The out_class port is absent.
  - nan_cnt and inf_cnt are tied to 0.
  - FIFO behaviour is otherwise identical.

## Test plan
- Reset, then idle → in_ready=1, out_valid=0, level=0, both counters 0.
- Push 0x40400000 (3.0), out_ready=0 → one cycle later out_valid=1, out_data=0x40400000, out_class=2, level=1. Data holds until out_ready=1, then out_valid=0.
- Push 0x80000000, 0x00000001, 0x7F800000, 0x7FC00000, 0x7F800001 with out_ready=1 → popped in that order with classes 0, 1, 3, 4, 5. nan_cnt=2, inf_cnt=1.
- Fill DEPTH=4 with out_ready=0 → in_ready=0 and level=4. A 5th word held with in_valid=1 is refused. Pop and push in the same cycle → push refused, level=3, then the next push is accepted.
- Stream 10 words 0x3F800000+i with out_ready toggling each cycle → all 10 received in order, no loss or duplication across pointer wrap.
- Fill 3 words, then assert rst for one cycle during a simultaneous push and pop → after reset level=0, out_valid=0, counters 0, and no old word reappears.
